// File: rtl/sync_fifo_ptr.sv
// Modulo-DEPTH wrapping pointer used for both the write and read side of sync_fifo.
// The pointer counts 0..DEPTH-1 and wraps back to 0, so DEPTH need not be a power of two.

module sync_fifo_ptr #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [ADDR_BITS-1:0] ptr_o
);

    localparam logic [ADDR_BITS-1:0] LastIdx = ADDR_BITS'(DEPTH - 1);

    logic [ADDR_BITS-1:0] ptr_q;
    logic [ADDR_BITS-1:0] ptr_d;

    // Next pointer: advance on increment, wrapping from the last slot to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            if (ptr_q == LastIdx) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ADDR_BITS'(1);
            end
        end
    end

    // Pointer register; reset outranks flush, and flush outranks any increment.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (clr_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, selectable FWFT or registered read,
// near-full/near-empty thresholds, fill level, sticky overflow/underflow and flush.
// Full and empty are told apart by the level register, so pointers carry no wrap bit.

module sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    localparam int LVL_BITS  = $clog2(DEPTH + 1),
    localparam int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic                we_i,
    input  logic                re_i,
    output logic [WIDTH-1:0]    rdata_o,
    output logic                rvalid_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                near_full_o,
    output logic                near_empty_o,
    output logic [LVL_BITS-1:0] level_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LVL_BITS-1:0]  level_q;
    logic [LVL_BITS-1:0]  level_d;
    logic                 overflow_q;
    logic                 overflow_d;
    logic                 underflow_q;
    logic                 underflow_d;
    logic [ADDR_BITS-1:0] wPtr;
    logic [ADDR_BITS-1:0] rPtr;
    logic                 readAccept;
    logic                 writeAccept;

    // Status flags come from the level register only, never from we_i/re_i.
    assign full_o       = (level_q == LVL_BITS'(DEPTH));
    assign empty_o      = (level_q == '0);
    assign near_full_o  = (level_q >= LVL_BITS'(AF_THRESH));
    assign near_empty_o = (level_q <= LVL_BITS'(AE_THRESH));
    assign level_o      = level_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;

    // A flush suppresses both accepts; a write into a full FIFO rides on a same-cycle read.
    assign readAccept  = re_i & ~empty_o & ~clr_i;
    assign writeAccept = we_i & ~clr_i & (~full_o | readAccept);

    sync_fifo_ptr #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (writeAccept),
        .ptr_o  (wPtr)
    );

    sync_fifo_ptr #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (readAccept),
        .ptr_o  (rPtr)
    );

    // Next level and sticky flags; the sticky bits only ever set here.
    always_comb begin
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (writeAccept && !readAccept) begin
            level_d = level_q + LVL_BITS'(1);
        end else if (readAccept && !writeAccept) begin
            level_d = level_q - LVL_BITS'(1);
        end
        if (we_i && !writeAccept) begin
            overflow_d = 1'b1;
        end
        if (re_i && empty_o) begin
            underflow_d = 1'b1;
        end
    end

    // Level and sticky flag registers; flush clears them and masks that cycle's requests.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr_i) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; deliberately not reset, stale contents are unreachable after a reset or flush.
    always_ff @(posedge clk_i) begin
        if (writeAccept) begin
            mem_q[wPtr] <= wdata_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; zeros when there is nothing to show.
            always_comb begin
                rdata_o  = '0;
                rvalid_o = ~empty_o;
                if (!empty_o) begin
                    rdata_o = mem_q[rPtr];
                end
            end
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            // Registered read: capture the head on an accepted read, otherwise hold data and drop valid.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (clr_i) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (readAccept) begin
                    rdata_q  <= mem_q[rPtr];
                    rvalid_q <= 1'b1;
                end else begin
                    rvalid_q <= 1'b0;
                end
            end

            assign rdata_o  = rdata_q;
            assign rvalid_o = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: one FWFT and one registered-read instance share the
// same stimulus and are compared every cycle against a queue-based reference model.

module tb_sync_fifo;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;
    localparam int LB = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          clr = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [W-1:0]  wdata = '0;

    logic [W-1:0]  rdataF, rdataS;
    logic          rvalidF, rvalidS, fullF, fullS, emptyF, emptyS;
    logic          nfF, nfS, neF, neS, ovF, ovS, unF, unS;
    logic [LB-1:0] lvlF, lvlS;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model state: queue contents, sticky flags, registered-read output.
    logic [W-1:0]  modelQ[$];
    logic          modelOv = 1'b0;
    logic          modelUn = 1'b0;
    logic [W-1:0]  modelRd = '0;
    logic          modelRv = 1'b0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
        .clk_i(clk), .rst_ni(rstN), .clr_i(clr), .wdata_i(wdata), .we_i(we), .re_i(re),
        .rdata_o(rdataF), .rvalid_o(rvalidF), .full_o(fullF), .empty_o(emptyF),
        .near_full_o(nfF), .near_empty_o(neF), .level_o(lvlF),
        .overflow_o(ovF), .underflow_o(unF)
    );

    sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_reg (
        .clk_i(clk), .rst_ni(rstN), .clr_i(clr), .wdata_i(wdata), .we_i(we), .re_i(re),
        .rdata_o(rdataS), .rvalid_o(rvalidS), .full_o(fullS), .empty_o(emptyS),
        .near_full_o(nfS), .near_empty_o(neS), .level_o(lvlS),
        .overflow_o(ovS), .underflow_o(unS)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Behavioural model of one clock edge, written in terms of queue occupancy.
    task automatic modelStep(input logic rstIn, input logic clrIn, input logic weIn,
                             input logic reIn, input logic [W-1:0] wd);
        int  n;
        bit  canRead;
        bit  canWrite;
        if (!rstIn || clrIn) begin
            modelQ.delete();
            modelOv = 1'b0;
            modelUn = 1'b0;
            modelRd = '0;
            modelRv = 1'b0;
        end else begin
            n        = modelQ.size();
            canRead  = reIn && (n > 0);
            canWrite = weIn && ((n < D) || canRead);
            if (reIn && n == 0) modelUn = 1'b1;
            if (weIn && !canWrite) modelOv = 1'b1;
            if (canRead) begin
                modelRd = modelQ.pop_front();
                modelRv = 1'b1;
            end else begin
                modelRv = 1'b0;
            end
            if (canWrite) modelQ.push_back(wd);
        end
    endtask

    task automatic checkAll();
        int           n;
        logic [W-1:0] head;
        n    = modelQ.size();
        head = (n > 0) ? modelQ[0] : '0;
        checkOutput("fwft.level",  32'(lvlF),    32'(n));
        checkOutput("fwft.full",   32'(fullF),   32'(n == D));
        checkOutput("fwft.empty",  32'(emptyF),  32'(n == 0));
        checkOutput("fwft.nfull",  32'(nfF),     32'(n >= AF));
        checkOutput("fwft.nempty", 32'(neF),     32'(n <= AE));
        checkOutput("fwft.ovf",    32'(ovF),     32'(modelOv));
        checkOutput("fwft.unf",    32'(unF),     32'(modelUn));
        checkOutput("fwft.rvalid", 32'(rvalidF), 32'(n > 0));
        checkOutput("fwft.rdata",  32'(rdataF),  32'(head));
        checkOutput("reg.level",   32'(lvlS),    32'(n));
        checkOutput("reg.full",    32'(fullS),   32'(n == D));
        checkOutput("reg.empty",   32'(emptyS),  32'(n == 0));
        checkOutput("reg.nfull",   32'(nfS),     32'(n >= AF));
        checkOutput("reg.nempty",  32'(neS),     32'(n <= AE));
        checkOutput("reg.ovf",     32'(ovS),     32'(modelOv));
        checkOutput("reg.unf",     32'(unS),     32'(modelUn));
        checkOutput("reg.rvalid",  32'(rvalidS), 32'(modelRv));
        checkOutput("reg.rdata",   32'(rdataS),  32'(modelRd));
    endtask

    // Drive one cycle of inputs on the falling edge, advance the model, check after the rising edge.
    task automatic applyStimulus(input logic rstIn, input logic clrIn, input logic weIn,
                                 input logic reIn, input logic [W-1:0] wd);
        @(negedge clk);
        rstN  = rstIn;
        clr   = clrIn;
        we    = weIn;
        re    = reIn;
        wdata = wd;
        modelStep(rstIn, clrIn, weIn, reIn, wd);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        // Reset, then idle.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("idle.rdata", 32'(rdataF), 32'h0);

        // Fill with 0x11..0x55, then one write too many.
        for (int i = 1; i <= D; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(i * 17));
            checkOutput("fill.level", 32'(lvlF), 32'(i));
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h66);
        checkOutput("ovf.level", 32'(lvlF), 32'd5);
        checkOutput("ovf.flag",  32'(ovS),  32'd1);

        // Simultaneous read/write while full, then drain across the pointer wrap.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        checkOutput("rw.regdata", 32'(rdataS), 32'h11);
        for (int i = 0; i < D; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        end
        checkOutput("drain.last", 32'(rdataS), 32'h77);

        // Read/write while empty: write lands, read rejected.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hA5);
        checkOutput("emptyrw.unf",  32'(unF),    32'd1);
        checkOutput("emptyrw.head", 32'(rdataF), 32'hA5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("emptyrw.reg",  32'(rdataS), 32'hA5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Level 3 with both sticky flags set, then flush with both requests high.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'($urandom));
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hEE);
        checkOutput("clr.level", 32'(lvlF), 32'd0);
        checkOutput("clr.ovf",   32'(ovF),  32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Random traffic, one-cycle reset, then a fresh word must come back.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'hBB);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hC3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("postrst.reg", 32'(rdataS), 32'hC3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Longer randomized run with occasional flushes and resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0),
                          1'($urandom), 1'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
